// File: rtl/bam_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bam_sched_pkg                                             |
// | Desc     : Shared types and constants for the Booth-multiplier       |
// |            access scheduler.                                         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package bam_sched_pkg;

  localparam int BAM_SCHED_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    READ    = 3'd3,
    RESP    = 3'd4
  } bam_sched_state_t;

  typedef logic bam_req_id_t;

endpackage
`default_nettype wire

// File: rtl/bam_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bam_scheduler_if                                          |
// | Desc     : Requester, response and multiplier-register signals of    |
// |            the scheduler. slave = scheduler, master = its environment.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface bam_scheduler_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req1_valid;
  logic             req0_ready;
  logic             req1_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_product;
  logic             resp_error;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_wr_a;
  logic             mul_wr_b;
  logic             mul_wr_out;
  logic             mul_rd_a;
  logic             mul_rd_b;
  logic             mul_rd_out;
  logic             mul_rst_a;
  logic             mul_rst_b;
  logic             mul_rst_out;
  logic [WIDTH-1:0] mul_product;
  logic             mul_err_a;
  logic             mul_err_b;
  logic             mul_err_out;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  resp_ready, mul_product, mul_err_a, mul_err_b, mul_err_out,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_product, resp_error,
    output mul_a, mul_b, mul_wr_a, mul_wr_b, mul_wr_out,
    output mul_rd_a, mul_rd_b, mul_rd_out, mul_rst_a, mul_rst_b, mul_rst_out
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output resp_ready, mul_product, mul_err_a, mul_err_b, mul_err_out,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_product, resp_error,
    input  mul_a, mul_b, mul_wr_a, mul_wr_b, mul_wr_out,
    input  mul_rd_a, mul_rd_b, mul_rd_out, mul_rst_a, mul_rst_b, mul_rst_out
  );
endinterface
`default_nettype wire

// File: rtl/bam_scheduler_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arbiter2                                               |
// | Desc     : Two-input round-robin arbiter; history moves on accept.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_arbiter2
  import bam_sched_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [1:0]  req,
  input  wire logic        accept,
  output bam_req_id_t      grant_id,
  output logic             grant_valid
);

  bam_req_id_t last_grant_q;
  bam_req_id_t last_grant_d;

  always_comb begin
    grant_valid  = |req;
    grant_id     = req[1];
    if (req == 2'b11) begin
      grant_id = ~last_grant_q;
    end
    last_grant_d = accept ? grant_id : last_grant_q;
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bam_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bam_scheduler                                             |
// | Desc     : Shares one registered Booth multiplier between two        |
// |            requesters. BAM_SCHED_SCRUB_EN: clear multiplier regs on  |
// |            every response handshake.                                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module bam_scheduler
  import bam_sched_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int COMPUTE_CYCLES = 1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  bam_scheduler_if.slave   bus
);

  bam_sched_state_t             state_q, state_d;
  logic [BAM_SCHED_CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]             a_q, a_d;
  logic [WIDTH-1:0]             b_q, b_d;
  logic [WIDTH-1:0]             prod_q, prod_d;
  bam_req_id_t                  id_q, id_d;
  logic                         err_q, err_d;
  logic                         wr_ab_q, wr_ab_d;
  logic                         rd_ab_q, rd_ab_d;
  logic                         wr_out_q, wr_out_d;
  logic                         rd_out_q, rd_out_d;
  logic                         resp_valid_q, resp_valid_d;

  bam_req_id_t                  grant_id;
  logic                         grant_valid;
  logic                         accept;
  logic                         mul_err;
  logic                         scrub;

  assign accept  = (state_q == IDLE) && grant_valid && !reset;
  assign mul_err = bus.mul_err_a | bus.mul_err_b | bus.mul_err_out;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         ({bus.req1_valid, bus.req0_valid}),
    .accept      (accept),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    id_d    = id_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = LOAD;
          id_d    = grant_id;
          a_d     = grant_id ? bus.req1_a : bus.req0_a;
          b_d     = grant_id ? bus.req1_b : bus.req0_b;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        state_d = COMPUTE;
        cnt_d   = BAM_SCHED_CNT_W'(COMPUTE_CYCLES - 1);
        err_d   = err_q | mul_err;
      end
      COMPUTE: begin
        err_d = err_q | mul_err;
        if (cnt_q == '0) begin
          state_d = READ;
        end else begin
          cnt_d = cnt_q - BAM_SCHED_CNT_W'(1);
        end
      end
      READ: begin
        err_d   = err_q | mul_err;
        prod_d  = bus.mul_product;
        state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Enables are decoded from the next state and registered, so the
    // multiplier pins come straight from flops.
    wr_ab_d      = (state_d == LOAD);
    rd_ab_d      = (state_d == COMPUTE);
    wr_out_d     = (state_d == COMPUTE) && (cnt_d == '0);
    rd_out_d     = (state_d == READ);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      prod_q       <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      wr_ab_q      <= 1'b0;
      rd_ab_q      <= 1'b0;
      wr_out_q     <= 1'b0;
      rd_out_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      prod_q       <= prod_d;
      id_q         <= id_d;
      err_q        <= err_d;
      wr_ab_q      <= wr_ab_d;
      rd_ab_q      <= rd_ab_d;
      wr_out_q     <= wr_out_d;
      rd_out_q     <= rd_out_d;
      resp_valid_q <= resp_valid_d;
    end
  end

`ifdef BAM_SCHED_SCRUB_EN
  assign scrub = resp_valid_q & bus.resp_ready;
`else
  assign scrub = 1'b0;
`endif

  assign bus.req0_ready   = accept && (grant_id == 1'b0);
  assign bus.req1_ready   = accept && (grant_id == 1'b1);
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_id      = id_q;
  assign bus.resp_product = prod_q;
  assign bus.resp_error   = err_q;
  assign bus.mul_a        = a_q;
  assign bus.mul_b        = b_q;
  assign bus.mul_wr_a     = wr_ab_q;
  assign bus.mul_wr_b     = wr_ab_q;
  assign bus.mul_wr_out   = wr_out_q;
  assign bus.mul_rd_a     = rd_ab_q;
  assign bus.mul_rd_b     = rd_ab_q;
  assign bus.mul_rd_out   = rd_out_q;
  assign bus.mul_rst_a    = reset | scrub;
  assign bus.mul_rst_b    = reset | scrub;
  assign bus.mul_rst_out  = reset | scrub;

endmodule
`default_nettype wire

// File: tb/tb_bam_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bam_scheduler                                          |
// | Desc     : Directed self-checking bench for bam_scheduler.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_bam_scheduler;

`ifdef BAM_SCHED_SCRUB_EN
  localparam logic SCRUB = 1'b1;
`else
  localparam logic SCRUB = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  bam_scheduler_if #(.WIDTH(32)) bus0 ();
  bam_scheduler_if #(.WIDTH(32)) bus3 ();

  bam_scheduler #(.WIDTH(32), .COMPUTE_CYCLES(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  bam_scheduler #(.WIDTH(32), .COMPUTE_CYCLES(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple registered-multiplier models: A, B and OUT registers.
  logic [31:0] ma0, mb0, mo0, ma3, mb3, mo3;
  always @(posedge clk) begin
    if (bus0.mul_rst_a) ma0 <= '0; else if (bus0.mul_wr_a) ma0 <= bus0.mul_a;
    if (bus0.mul_rst_b) mb0 <= '0; else if (bus0.mul_wr_b) mb0 <= bus0.mul_b;
    if (bus0.mul_rst_out) mo0 <= '0; else if (bus0.mul_wr_out) mo0 <= ma0 * mb0;
    if (bus3.mul_rst_a) ma3 <= '0; else if (bus3.mul_wr_a) ma3 <= bus3.mul_a;
    if (bus3.mul_rst_b) mb3 <= '0; else if (bus3.mul_wr_b) mb3 <= bus3.mul_b;
    if (bus3.mul_rst_out) mo3 <= '0; else if (bus3.mul_wr_out) mo3 <= ma3 * mb3;
  end
  assign bus0.mul_product = mo0;
  assign bus3.mul_product = mo3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Raise a request, wait for its grant, and return in the LOAD cycle.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    if (id == 0) begin
      bus0.req0_a = a; bus0.req0_b = b; bus0.req0_valid = 1'b1;
    end else begin
      bus0.req1_a = a; bus0.req1_b = b; bus0.req1_valid = 1'b1;
    end
    #1;
    while (!((id == 0) ? bus0.req0_ready : bus0.req1_ready) && n < 30) begin
      tick();
      n++;
    end
    check("grant_wait", 32'(n < 30), 32'd1);
    tick();
    if (id == 0) bus0.req0_valid = 1'b0; else bus0.req1_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!bus0.resp_valid && n < 30) begin
      tick();
      n++;
    end
    check("resp_wait", 32'(bus0.resp_valid), 32'd1);
  endtask

  initial begin
    int gid;
    int bad;
    int lat;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus0.req0_valid = 0; bus0.req1_valid = 0; bus0.resp_ready = 1;
    bus0.req0_a = 0; bus0.req0_b = 0; bus0.req1_a = 0; bus0.req1_b = 0;
    bus0.mul_err_a = 0; bus0.mul_err_b = 0; bus0.mul_err_out = 0;
    bus3.req0_valid = 0; bus3.req1_valid = 0; bus3.resp_ready = 1;
    bus3.req0_a = 0; bus3.req0_b = 0; bus3.req1_a = 0; bus3.req1_b = 0;
    bus3.mul_err_a = 0; bus3.mul_err_b = 0; bus3.mul_err_out = 0;
    tick();
    tick();

    // Reset state
    check("rst_mul_rst_a", 32'(bus0.mul_rst_a), 32'd1);
    check("rst_resp_valid", 32'(bus0.resp_valid), 32'd0);
    check("rst_product", bus0.resp_product, 32'd0);
    check("rst_en", 32'({bus0.mul_wr_a, bus0.mul_wr_out, bus0.mul_rd_a, bus0.mul_rd_out}), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_release_mul_rst", 32'(bus0.mul_rst_out), 32'd0);

    // Single request, cycle-accurate
    bus0.req0_a = 32'd7; bus0.req0_b = 32'd6; bus0.req0_valid = 1'b1;
    #1;
    check("c0_req0_ready", 32'(bus0.req0_ready), 32'd1);
    check("c0_req1_ready", 32'(bus0.req1_ready), 32'd0);
    tick();
    bus0.req0_valid = 1'b0;
    check("c1_wr_ab", 32'({bus0.mul_wr_a, bus0.mul_wr_b}), 32'd3);
    check("c1_mul_a", bus0.mul_a, 32'd7);
    tick();
    check("c2_rd_ab_wr_out", 32'({bus0.mul_rd_a, bus0.mul_rd_b, bus0.mul_wr_out}), 32'd7);
    tick();
    check("c3_rd_out_rd_a", 32'({bus0.mul_rd_out, bus0.mul_rd_a}), 32'd2);
    tick();
    check("c4_resp_valid", 32'(bus0.resp_valid), 32'd1);
    check("c4_product", bus0.resp_product, 32'd42);
    check("c4_id_err", 32'({bus0.resp_id, bus0.resp_error}), 32'd0);
    tick();
    check("c5_resp_valid", 32'(bus0.resp_valid), 32'd0);

    // Fairness from fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus0.req0_a = 32'd3; bus0.req0_b = 32'd4;
    bus0.req1_a = 32'd5; bus0.req1_b = 32'd5;
    bus0.req0_valid = 1'b1; bus0.req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      bad = 0;
      while (!(bus0.req0_ready || bus0.req1_ready) && bad < 30) begin
        tick();
        bad++;
      end
      gid = bus0.req1_ready ? 1 : 0;
      check("fair_grant", 32'(gid), 32'(i % 2));
      tick();
      wait_resp();
      check("fair_id", 32'(bus0.resp_id), 32'(gid));
      check("fair_product", bus0.resp_product, (gid == 1) ? 32'd25 : 32'd12);
      if (i == 3) begin
        bus0.req0_valid = 1'b0; bus0.req1_valid = 1'b0;
      end
      tick();
    end

    // Backpressure
    bus0.resp_ready = 1'b0;
    issue(0, 32'd9, 32'd9);
    bus0.req1_a = 32'd2; bus0.req1_b = 32'd10; bus0.req1_valid = 1'b1;
    wait_resp();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus0.resp_valid || bus0.resp_product != 32'd81 || bus0.req1_ready) bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    check("bp_product", bus0.resp_product, 32'd81);
    bus0.resp_ready = 1'b1;
    #1;
    check("bp_no_ready_in_resp", 32'(bus0.req1_ready), 32'd0);
    tick();
    check("bp_idle_grant", 32'(bus0.req1_ready), 32'd1);
    check("bp_valid_drop", 32'(bus0.resp_valid), 32'd0);
    tick();
    bus0.req1_valid = 1'b0;
    wait_resp();
    check("bp_req1_product", bus0.resp_product, 32'd20);
    check("bp_req1_id", 32'(bus0.resp_id), 32'd1);
    tick();

    // Error during COMPUTE, then clean operation
    issue(0, 32'hFFFF_FFFD, 32'd5);
    tick();
    bus0.mul_err_b = 1'b1;
    tick();
    bus0.mul_err_b = 1'b0;
    wait_resp();
    check("err_product", bus0.resp_product, 32'hFFFF_FFF1);
    check("err_flag", 32'(bus0.resp_error), 32'd1);
    tick();
    issue(0, 32'd1, 32'd1);
    wait_resp();
    check("err_clear", 32'(bus0.resp_error), 32'd0);
    check("err_next_product", bus0.resp_product, 32'd1);
    tick();

    // Reset in COMPUTE
    issue(0, 32'd4, 32'd4);
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_mul_rst", 32'({bus0.mul_rst_a, bus0.mul_rst_b, bus0.mul_rst_out}), 32'd7);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_outputs", 32'({bus0.resp_valid, bus0.resp_error, bus0.mul_wr_a,
                                   bus0.mul_wr_out, bus0.mul_rd_a, bus0.mul_rd_out}), 32'd0);
    check("mid_rst_product", bus0.resp_product, 32'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus0.resp_valid) bad++;
    end
    check("mid_rst_no_resp", 32'(bad), 32'd0);
    issue(1, 32'd6, 32'd7);
    wait_resp();
    check("post_rst_product", bus0.resp_product, 32'd42);
    check("post_rst_id", 32'(bus0.resp_id), 32'd1);
    tick();

    // COMPUTE_CYCLES = 3 instance: latency and scrub pulse
    bus3.req0_a = 32'd11; bus3.req0_b = 32'd3; bus3.req0_valid = 1'b1;
    #1;
    check("c3_grant", 32'(bus3.req0_ready), 32'd1);
    tick();
    bus3.req0_valid = 1'b0;
    lat = 1;
    while (!bus3.resp_valid && lat < 30) begin
      tick();
      lat++;
    end
    check("c3_latency", 32'(lat), 32'd6);
    check("c3_product", bus3.resp_product, 32'd33);
    check("c3_scrub_pulse", 32'({bus3.mul_rst_a, bus3.mul_rst_b, bus3.mul_rst_out}),
          SCRUB ? 32'd7 : 32'd0);
    tick();
    check("c3_scrub_end", 32'(bus3.mul_rst_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
